// File: rtl/load_store_unit.sv
// Data-memory access stage: latches a load/store from execute, runs one valid/ready
// transaction to data memory and returns the lane-extracted, extended load result.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] trim_out,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] trim_q, trim_d;
    logic        misalign_q, misalign_d;

    logic        req_legal;
    logic [3:0]  wstrb_new;
    logic [31:0] wdata_new;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    // Encoding and alignment check for the request presented in IDLE.
    always_comb begin
        req_legal = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000:  req_legal = 1'b1;
                3'b001:  req_legal = ~req_addr[0];
                3'b010:  req_legal = (req_addr[1:0] == 2'b00);
                default: req_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: req_legal = 1'b1;
                3'b001, 3'b101: req_legal = ~req_addr[0];
                3'b010:         req_legal = (req_addr[1:0] == 2'b00);
                default:        req_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        wstrb_new = 4'b1111;
        wdata_new = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                wstrb_new = 4'b0001 << req_addr[1:0];
                wdata_new = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wstrb_new = 4'b0011 << req_addr[1:0];
                wdata_new = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!req_we) begin
            wstrb_new = 4'b0000;
        end
    end

    assign rdata_shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_ext = {24'h0, rdata_shifted[7:0]};
            3'b101:  load_ext = {16'h0, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        addr_d     = addr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        trim_d     = trim_q;
        misalign_d = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_legal) begin
                        busy     = 1'b1;
                        we_d     = req_we;
                        funct3_d = req_funct3;
                        off_d    = req_addr[1:0];
                        addr_d   = {req_addr[31:2], 2'b00};
                        wstrb_d  = wstrb_new;
                        wdata_d  = wdata_new;
                        state_d  = StReq;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            StReq: begin
                busy = 1'b1;
                if (mem_ready) begin
                    state_d = we_q ? StDone : StWait;
                end
            end
            StWait: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    trim_d  = load_ext;
                    state_d = StDone;
                end
            end
            StDone: begin
                // The finished instruction is still on req_*, so it is not resampled here.
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            addr_q     <= 32'h0;
            wstrb_q    <= 4'b0000;
            wdata_q    <= 32'h0;
            trim_q     <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            trim_q     <= trim_d;
            misalign_q <= misalign_d;
        end
    end

    assign mem_valid = (state_q == StReq);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;
    assign trim_out  = trim_q;
    assign misalign  = misalign_q;

endmodule
